// File: rtl/rx_sw_pkg.sv
// Shared definitions for the receive-side frame scheduler: descriptor layout,
// frame-length width and the arbiter FSM state encoding.
package rx_sw_pkg;

  localparam int FRAME_LENW  = 11;
  localparam int PTR_W       = 16;
  localparam int PTR_ERR_BIT = 15;
  localparam int PTR_LEN_MSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PTR_RD   = 3'd1,
    ST_PTR_WAIT = 3'd2,
    ST_XFER     = 3'd3,
    ST_DRAIN    = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rx_port_arbiter_rr_pick.sv
// Round-robin next-grant picker: first requesting port after rr_ptr, wrapping.
module rr_pick #(
  parameter int NPORT = 4,
  parameter int PW    = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [PW-1:0]    grant,
  output logic             grant_valid
);

  // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = NPORT; i >= 1; i--) begin
      idx = (int'(rr_ptr) + i) % NPORT;
      if (req[idx]) begin
        grant       = PW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_port_arbiter.sv
// Round-robin frame scheduler: pops one descriptor from the chosen port, then
// streams (good) or silently drains (bad) that frame's bytes.
//
// state       | meaning
// ST_IDLE     | wait for sw_ready and a non-empty descriptor FIFO, pick port
// ST_PTR_RD   | pop descriptor of granted port
// ST_PTR_WAIT | descriptor valid: latch length/error, choose path
// ST_XFER     | pop len bytes, forwarded on the output one cycle later
// ST_DRAIN    | pop len bytes, discard, pulse drop_pulse after the last
module rx_port_arbiter
  import rx_sw_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int PW    = 2,
  parameter int LENW  = FRAME_LENW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORT-1:0]     ptr_fifo_empty,
  input  logic [16*NPORT-1:0]  ptr_fifo_dout,
  output logic [NPORT-1:0]     ptr_fifo_rd,
  input  logic [8*NPORT-1:0]   data_fifo_dout,
  output logic [NPORT-1:0]     data_fifo_rd,
  input  logic                 sw_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [PW-1:0]        out_port,
  output logic [LENW-1:0]      out_len,
  output logic                 drop_pulse
);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [LENW-1:0] len_q, len_d;
  logic            err_q, err_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;
  logic            drop_q, drop_d;

  logic [PW-1:0]   pick;
  logic            pick_valid;
  logic [LENW-1:0] desc_len;
  logic            desc_err;

  rr_pick #(.NPORT(NPORT), .PW(PW)) u_rr_pick (
    .req         (~ptr_fifo_empty),
    .rr_ptr      (rr_ptr_q),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  assign desc_len = LENW'(ptr_fifo_dout[16*int'(grant_q) +: PTR_LEN_MSB+1]);
  assign desc_err = ptr_fifo_dout[16*int'(grant_q) + PTR_ERR_BIT];

  // Next-state, FIFO pops and next output flags.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    len_d        = len_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    drop_d       = 1'b0;
    ptr_fifo_rd  = '0;
    data_fifo_rd = '0;
    case (state_q)
      ST_IDLE: begin
        if (sw_ready && pick_valid) begin
          grant_d  = pick;
          rr_ptr_d = pick;
          state_d  = ST_PTR_RD;
        end
      end
      ST_PTR_RD: begin
        ptr_fifo_rd[grant_q] = 1'b1;
        state_d              = ST_PTR_WAIT;
      end
      ST_PTR_WAIT: begin
        len_d = desc_len;
        err_d = desc_err;
        cnt_d = desc_len;
        if (desc_len == '0)  state_d = ST_IDLE;
        else if (desc_err)   state_d = ST_DRAIN;
        else                 state_d = ST_XFER;
      end
      ST_XFER: begin
        data_fifo_rd[grant_q] = 1'b1;
        out_valid_d           = 1'b1;
        out_sof_d             = (cnt_q == len_q);
        out_eof_d             = (cnt_q == LENW'(1));
        cnt_d                 = cnt_q - LENW'(1);
        if (cnt_q == LENW'(1)) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        data_fifo_rd[grant_q] = 1'b1;
        drop_d                = (cnt_q == LENW'(1));
        cnt_d                 = cnt_q - LENW'(1);
        if (cnt_q == LENW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output-flag registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= PW'(NPORT-1);
      grant_q     <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      len_q       <= len_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      drop_q      <= drop_d;
    end
  end

  // The data FIFO output already carries the byte the cycle after its pop, so
  // the byte is muxed straight through beside the registered flags; grant_q
  // still names this frame's port on the eof cycle.
  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? data_fifo_dout[8*int'(grant_q) +: 8] : 8'h00;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_port   = grant_q;
  assign out_len    = len_q;
  assign drop_pulse = drop_q;

endmodule
